// File: rtl/display_pkg.sv
// Shared seven-segment constants and BCD digit width for the display path.
// Segment patterns are active-low, bit 0 = segment a ... bit 6 = segment g.
package display_pkg;

    localparam int unsigned DIGIT_W = 4;

    localparam logic [6:0] SEG_0     = 7'h40;
    localparam logic [6:0] SEG_1     = 7'h79;
    localparam logic [6:0] SEG_2     = 7'h24;
    localparam logic [6:0] SEG_3     = 7'h30;
    localparam logic [6:0] SEG_4     = 7'h19;
    localparam logic [6:0] SEG_5     = 7'h12;
    localparam logic [6:0] SEG_6     = 7'h02;
    localparam logic [6:0] SEG_7     = 7'h78;
    localparam logic [6:0] SEG_8     = 7'h00;
    localparam logic [6:0] SEG_9     = 7'h10;
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    // Codes 10-15 cannot be produced by the counter; show them as blank.
    function automatic logic [6:0] seg_encode(input logic [DIGIT_W-1:0] digit);
        case (digit)
            4'd0:    return SEG_0;
            4'd1:    return SEG_1;
            4'd2:    return SEG_2;
            4'd3:    return SEG_3;
            4'd4:    return SEG_4;
            4'd5:    return SEG_5;
            4'd6:    return SEG_6;
            4'd7:    return SEG_7;
            4'd8:    return SEG_8;
            4'd9:    return SEG_9;
            default: return SEG_BLANK;
        endcase
    endfunction

endpackage

// File: rtl/seg7_decoder.sv
// BCD digit to active-low seven-segment pattern, with optional blanking of a
// zero digit (used to suppress a leading-zero tens display).
module seg7_decoder
    import display_pkg::*;
#(
    parameter bit BLANK_ZERO = 1'b0
) (
    input  logic [3:0] digit,
    output logic [6:0] seg
);

    always_comb begin
        seg = seg_encode(digit);
        if (BLANK_ZERO && (digit == '0)) begin
            seg = SEG_BLANK;
        end
    end

endmodule

// File: rtl/bcd_tick_counter.sv
// Two-digit BCD up/down counter stepped by rising edges of the divided clock
// level, with run/direction/clear controls, a wrap pulse and segment drive.
module bcd_tick_counter
    import display_pkg::*;
#(
    parameter int unsigned MAX_COUNT   = 99,
    parameter int unsigned START_VALUE = 0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tick_in,
    input  logic       run,
    input  logic       up_down,
    input  logic       clear,
    output logic [3:0] ones,
    output logic [3:0] tens,
    output logic [6:0] hex0,
    output logic [6:0] hex1,
    output logic       wrap
);

    if ((MAX_COUNT < 1) || (MAX_COUNT > 99) || (START_VALUE > MAX_COUNT)) begin : g_bad_params
        $error("bcd_tick_counter: MAX_COUNT must be 1..99 and START_VALUE <= MAX_COUNT");
    end

    localparam logic [DIGIT_W-1:0] MAX_ONES   = DIGIT_W'(MAX_COUNT % 10);
    localparam logic [DIGIT_W-1:0] MAX_TENS   = DIGIT_W'(MAX_COUNT / 10);
    localparam logic [DIGIT_W-1:0] START_ONES = DIGIT_W'(START_VALUE % 10);
    localparam logic [DIGIT_W-1:0] START_TENS = DIGIT_W'(START_VALUE / 10);

    logic tick_prev;
    logic step;
    logic at_max;
    logic at_zero;

    // tick_prev follows tick_in even while paused, so resuming never fakes an edge.
    assign step    = tick_in & ~tick_prev;
    assign at_max  = (tens == MAX_TENS) && (ones == MAX_ONES);
    assign at_zero = (tens == '0) && (ones == '0);

    always_ff @(posedge clk) begin
        if (reset) begin
            tick_prev <= 1'b0;
            ones      <= START_ONES;
            tens      <= START_TENS;
            wrap      <= 1'b0;
        end else begin
            tick_prev <= tick_in;
            if (clear) begin
                ones <= START_ONES;
                tens <= START_TENS;
                wrap <= 1'b0;
            end else if (run && step && up_down) begin
                if (at_max) begin
                    ones <= '0;
                    tens <= '0;
                    wrap <= 1'b1;
                end else if (ones == 4'd9) begin
                    ones <= '0;
                    tens <= tens + 4'd1;
                    wrap <= 1'b0;
                end else begin
                    ones <= ones + 4'd1;
                    wrap <= 1'b0;
                end
            end else if (run && step) begin
                if (at_zero) begin
                    ones <= MAX_ONES;
                    tens <= MAX_TENS;
                    wrap <= 1'b1;
                end else if (ones == '0) begin
                    ones <= 4'd9;
                    tens <= tens - 4'd1;
                    wrap <= 1'b0;
                end else begin
                    ones <= ones - 4'd1;
                    wrap <= 1'b0;
                end
            end else begin
                wrap <= 1'b0;
            end
        end
    end

    seg7_decoder #(.BLANK_ZERO(1'b0)) u_ones_seg (
        .digit (ones),
        .seg   (hex0)
    );

    seg7_decoder #(.BLANK_ZERO(1'b1)) u_tens_seg (
        .digit (tens),
        .seg   (hex1)
    );

endmodule

// File: tb/tb_bcd_tick_counter.sv
// Self-checking bench: directed vector table, hand sequences for a MAX_COUNT=59 /
// START_VALUE=5 instance, and random stimulus against an integer-count model.
module tb_bcd_tick_counter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic r_reset = 1'b1, r_clear = 1'b0, r_run = 1'b0, r_ud = 1'b1, r_tick = 1'b0;

    logic [3:0] ones_a, tens_a, ones_b, tens_b;
    logic [6:0] hex0_a, hex1_a, hex0_b, hex1_b;
    logic       wrap_a, wrap_b;

    bcd_tick_counter dut_a (
        .clk(clk), .reset(r_reset), .tick_in(r_tick), .run(r_run), .up_down(r_ud),
        .clear(r_clear), .ones(ones_a), .tens(tens_a), .hex0(hex0_a), .hex1(hex1_a),
        .wrap(wrap_a)
    );

    bcd_tick_counter #(.MAX_COUNT(59), .START_VALUE(5)) dut_b (
        .clk(clk), .reset(r_reset), .tick_in(r_tick), .run(r_run), .up_down(r_ud),
        .clear(r_clear), .ones(ones_b), .tens(tens_b), .hex0(hex0_b), .hex1(hex1_b),
        .wrap(wrap_b)
    );

    // Reference model: plain integer count per instance, wrap computed from the rules.
    localparam logic [6:0] SEG_REF [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                                            7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
    bit m_prev = 1'b0;
    int m_cnt_a = 0, m_cnt_b = 5;
    bit m_wrap_a = 1'b0, m_wrap_b = 1'b0;
    logic m_step;
    assign m_step = r_tick & ~m_prev;

    function automatic int model_next(input int cnt, input int maxc, input int start);
        if (r_reset || r_clear) return start;
        if (r_run && m_step) return r_ud ? (cnt + 1) % (maxc + 1) : ((cnt == 0) ? maxc : cnt - 1);
        return cnt;
    endfunction

    function automatic bit model_wrap(input int cnt, input int maxc);
        return !r_reset && !r_clear && r_run && m_step && (r_ud ? (cnt == maxc) : (cnt == 0));
    endfunction

    always @(posedge clk) begin
        m_prev   <= r_reset ? 1'b0 : r_tick;
        m_cnt_a  <= model_next(m_cnt_a, 99, 0);
        m_cnt_b  <= model_next(m_cnt_b, 59, 5);
        m_wrap_a <= model_wrap(m_cnt_a, 99);
        m_wrap_b <= model_wrap(m_cnt_b, 59);
    end

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [3:0] o, input logic [3:0] t,
                         input logic [6:0] h0, input logic [6:0] h1, input logic w,
                         input int exp, input bit exp_w);
        logic [3:0] eo, et;
        logic [6:0] eh0, eh1;
        eo  = 4'(exp % 10);
        et  = 4'(exp / 10);
        eh0 = SEG_REF[exp % 10];
        eh1 = (et == 0) ? 7'h7F : SEG_REF[exp / 10];
        n_checks++;
        if (o === eo && t === et && h0 === eh0 && h1 === eh1 && w === exp_w) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got tens=%0d ones=%0d hex1=%h hex0=%h wrap=%b, expected tens=%0d ones=%0d hex1=%h hex0=%h wrap=%b",
                     name, t, o, h1, h0, w, et, eo, eh1, eh0, exp_w);
        end
    endtask

    typedef struct {
        bit rst, clr, run, ud, tick;
        int exp_a;
        bit exp_wrap_a;
    } vec_t;
    vec_t vecs[$];

    task automatic add(input bit rst, input bit clr, input bit run, input bit ud,
                       input bit tick, input int exp_a, input bit exp_wrap_a);
        vec_t v;
        v.rst = rst; v.clr = clr; v.run = run; v.ud = ud; v.tick = tick;
        v.exp_a = exp_a; v.exp_wrap_a = exp_wrap_a;
        vecs.push_back(v);
    endtask

    // Drive at the falling edge; the rising edge consumes; check at the next falling edge.
    task automatic apply(input bit rst, input bit clr, input bit run, input bit ud, input bit tick);
        r_reset = rst; r_clear = clr; r_run = run; r_ud = ud; r_tick = tick;
        @(negedge clk);
    endtask

    initial begin
        add(1,0,0,1,0, 0,0); add(1,0,0,1,0, 0,0);
        add(0,0,0,1,0, 0,0); add(0,0,0,1,0, 0,0);
        for (int k = 1; k <= 12; k++) begin
            add(0,0,1,1,1, k,0); add(0,0,1,1,0, k,0);
        end
        add(0,1,1,1,0, 0,0);
        add(0,0,1,0,1, 99,1); add(0,0,1,0,0, 99,0);
        add(0,0,1,0,1, 98,0); add(0,0,1,0,0, 98,0);
        add(0,0,1,1,1, 99,0); add(0,0,1,1,0, 99,0);
        add(0,0,1,1,1, 0,1);  add(0,0,1,1,0, 0,0);
        for (int k = 1; k <= 10; k++) begin
            add(0,0,1,1,1, k,0); add(0,0,1,1,0, k,0);
        end
        add(0,0,1,0,1, 9,0);  add(0,0,1,0,0, 9,0);
        add(0,0,1,1,0, 9,0);  add(0,0,1,1,1, 10,0);
        add(0,0,0,1,1, 10,0); add(0,0,1,1,1, 10,0);
        add(0,0,1,1,0, 10,0); add(0,0,1,1,1, 11,0); add(0,0,1,1,0, 11,0);
        add(0,0,0,1,1, 11,0); add(0,0,0,1,0, 11,0);
        add(0,1,1,1,1, 0,0);  add(0,0,1,1,0, 0,0);
        add(0,0,1,1,1, 1,0);  add(0,0,1,1,0, 1,0); add(0,0,1,1,1, 2,0);
        add(1,0,1,1,0, 0,0);  add(0,0,1,1,0, 0,0);

        @(negedge clk);
        foreach (vecs[i]) begin
            apply(vecs[i].rst, vecs[i].clr, vecs[i].run, vecs[i].ud, vecs[i].tick);
            check($sformatf("vec%0d_a", i), ones_a, tens_a, hex0_a, hex1_a, wrap_a,
                  vecs[i].exp_a, vecs[i].exp_wrap_a);
            check($sformatf("vec%0d_b_model", i), ones_b, tens_b, hex0_b, hex1_b, wrap_b,
                  m_cnt_b, m_wrap_b);
        end

        apply(1,0,0,0,0);
        check("b_reset_start", ones_b, tens_b, hex0_b, hex1_b, wrap_b, 5, 0);
        for (int k = 4; k >= 0; k--) begin
            apply(0,0,1,0,1);
            check("b_down", ones_b, tens_b, hex0_b, hex1_b, wrap_b, k, 0);
            apply(0,0,1,0,0);
        end
        apply(0,0,1,0,1);
        check("b_down_wrap", ones_b, tens_b, hex0_b, hex1_b, wrap_b, 59, 1);
        apply(0,0,1,1,0);
        check("b_wrap_end", ones_b, tens_b, hex0_b, hex1_b, wrap_b, 59, 0);
        apply(0,0,1,1,1);
        check("b_up_wrap_59", ones_b, tens_b, hex0_b, hex1_b, wrap_b, 0, 1);
        apply(0,0,1,1,0);
        check("b_up_wrap_end", ones_b, tens_b, hex0_b, hex1_b, wrap_b, 0, 0);
        apply(0,1,1,1,1);
        check("b_clear_beats_step", ones_b, tens_b, hex0_b, hex1_b, wrap_b, 5, 0);
        check("a_clear_beats_step", ones_a, tens_a, hex0_a, hex1_a, wrap_a, m_cnt_a, m_wrap_a);

        begin
            bit ud = 1'b1;
            for (int n = 0; n < 3000; n++) begin
                if ($urandom_range(31) == 0) ud = ~ud;
                apply($urandom_range(127) == 0, $urandom_range(31) == 0,
                      $urandom_range(3) != 0, ud, 1'($urandom_range(1)));
                check("rand_a", ones_a, tens_a, hex0_a, hex1_a, wrap_a, m_cnt_a, m_wrap_a);
                check("rand_b", ones_b, tens_b, hex0_b, hex1_b, wrap_b, m_cnt_b, m_wrap_b);
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
